// File: rtl/trivium_pkg.sv
// ============================================================================
//  Module  : trivium_pkg
//  Purpose : Shared types and sizing constants for the Trivium keystream
//            sequencer and its byte packer.
//  Rev     : 1.0
// ============================================================================
`default_nettype none

package trivium_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_INIT   = 2'd1,
    ST_WARMUP = 2'd2,
    ST_RUN    = 2'd3
  } state_e;

  localparam int KEY_W             = 80;
  localparam int IV_W              = 80;
  localparam int WARMUP_CYCLES_DEF = 4 * 288;
  localparam int PACK_CNT_W        = 3;

endpackage

`default_nettype wire

// File: rtl/ks_byte_packer.sv
// ============================================================================
//  Module  : ks_byte_packer
//  Purpose : Packs keystream bits LSB-first into bytes, holds one finished
//            byte for the FIFO and stalls the core only when a second byte
//            would complete while the first is still waiting.
//  Rev     : 1.0
// ============================================================================
`default_nettype none

module ks_byte_packer
  import trivium_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       run_i,
  input  logic       clear_i,
  input  logic       bit_i,
  input  logic       fifo_full_i,
  output logic       advance_o,
  output logic       wr_en_o,
  output logic [7:0] wr_data_o
);

  logic [6:0]            sreg_q;
  logic [7:0]            buf_q;
  logic [PACK_CNT_W-1:0] cnt_q;
  logic                  valid_q;
  logic                  stall;
  logic                  last_bit;
  logic                  complete;

  assign last_bit  = (cnt_q == {PACK_CNT_W{1'b1}});
  assign stall     = valid_q && fifo_full_i && last_bit;
  assign advance_o = run_i && !stall;
  assign complete  = advance_o && last_bit;
  assign wr_en_o   = valid_q && !fifo_full_i;
  assign wr_data_o = buf_q;

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      sreg_q  <= '0;
      buf_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      if (advance_o) begin
        // Seven partial bits ride in from the top, so the first lands in bit0.
        sreg_q <= {bit_i, sreg_q[6:1]};
        cnt_q  <= cnt_q + 1'b1;
      end
      if (complete) begin
        buf_q   <= {bit_i, sreg_q};
        valid_q <= 1'b1;
      end else if (wr_en_o) begin
        valid_q <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/trivium_ks_ctrl.sv
// ============================================================================
//  Module  : trivium_ks_ctrl
//  Purpose : Collects key/IV bytes, loads and warms up the Trivium core, then
//            streams packed keystream bytes into the TX FIFO.
//  Rev     : 1.0
// ============================================================================
`default_nettype none

module trivium_ks_ctrl
  import trivium_pkg::*;
#(
  parameter int KEY_BYTES     = KEY_W / 8,
  parameter int IV_BYTES      = IV_W / 8,
  parameter int WARMUP_CYCLES = WARMUP_CYCLES_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             cfg_data,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic                   start,
  input  logic                   stop,
  output logic [8*KEY_BYTES-1:0] core_key,
  output logic [8*IV_BYTES-1:0]  core_iv,
  output logic                   core_load,
  output logic                   core_enable,
  input  logic                   core_ks_bit,
  output logic                   fifo_wr_en,
  output logic [7:0]             fifo_wr_data,
  input  logic                   fifo_full,
  output logic                   cfg_loaded,
  output logic                   busy,
  output logic                   ks_running
);

  localparam int CFG_BYTES = KEY_BYTES + IV_BYTES;
  localparam int IDX_W     = $clog2(CFG_BYTES);
  localparam int WARM_W    = $clog2(WARMUP_CYCLES);

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q;
  logic [8*KEY_BYTES-1:0] key_q, key_d;
  logic [8*IV_BYTES-1:0]  iv_q, iv_d;
  logic                   loaded_q;
  logic [WARM_W-1:0]      warm_q;
  logic                   cfg_xfer;
  logic                   pack_advance;
  logic                   pack_run;
  logic                   pack_clear;

  assign cfg_ready  = (state_q == ST_IDLE) && !rst;
  assign cfg_xfer   = cfg_valid && cfg_ready;
  assign core_load  = (state_q == ST_INIT);
  assign busy       = (state_q != ST_IDLE);
  assign ks_running = (state_q == ST_RUN);
  assign cfg_loaded = loaded_q;
  assign core_key   = key_q;
  assign core_iv    = iv_q;
  assign pack_run   = (state_q == ST_RUN);
  assign pack_clear = (state_d != ST_RUN);
  assign core_enable = (state_q == ST_WARMUP) || pack_advance;

  always_comb begin
    state_d = state_q;
    if (state_q != ST_IDLE && stop) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   if (start && loaded_q && !stop) state_d = ST_INIT;
        ST_INIT:   state_d = ST_WARMUP;
        ST_WARMUP: if (warm_q == WARM_W'(WARMUP_CYCLES - 1)) state_d = ST_RUN;
        ST_RUN:    state_d = ST_RUN;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Byte k of the config stream fills key bytes first, then IV bytes.
  always_comb begin
    key_d = key_q;
    iv_d  = iv_q;
    for (int k = 0; k < KEY_BYTES; k++) begin
      if (int'(idx_q) == k) key_d[8*k +: 8] = cfg_data;
    end
    for (int k = 0; k < IV_BYTES; k++) begin
      if (int'(idx_q) == KEY_BYTES + k) iv_d[8*k +: 8] = cfg_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      key_q    <= '0;
      iv_q     <= '0;
      loaded_q <= 1'b0;
      warm_q   <= '0;
    end else begin
      state_q <= state_d;
      warm_q  <= (state_q == ST_WARMUP) ? warm_q + 1'b1 : '0;
      if (cfg_xfer) begin
        key_q <= key_d;
        iv_q  <= iv_d;
        if (idx_q == IDX_W'(CFG_BYTES - 1)) begin
          idx_q    <= '0;
          loaded_q <= 1'b1;
        end else begin
          idx_q <= idx_q + 1'b1;
        end
      end
    end
  end

  ks_byte_packer u_packer (
    .clk         (clk),
    .rst         (rst),
    .run_i       (pack_run),
    .clear_i     (pack_clear),
    .bit_i       (core_ks_bit),
    .fifo_full_i (fifo_full),
    .advance_o   (pack_advance),
    .wr_en_o     (fifo_wr_en),
    .wr_data_o   (fifo_wr_data)
  );

endmodule

`default_nettype wire
